// File: rtl/mc_hazard_scoreboard_pkg.sv
// Shared constants and state encoding for the multi-cycle hazard scoreboard.
// Unit and bank indices match the decoder's unit select and WB_rb_sel encoding.
package mc_hazard_scoreboard_pkg;

   localparam int UNIT_MULDIV = 0;
   localparam int UNIT_FPU    = 1;

   localparam int BANK_INT = 0;
   localparam int BANK_FP  = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_TMO  = 2'd2
   } unit_state_t;

endpackage

// File: rtl/mc_unit_tracker.sv
// Per-unit tracker: busy/timeout FSM, saturating busy-cycle counter and the
// destination held for writeback steering.
module mc_unit_tracker
   import mc_hazard_scoreboard_pkg::*;
#(
   parameter int RA_W    = 5,
   parameter int BK_W    = 1,
   parameter int TIMEOUT = 64
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            flush_i,
   input  logic            fire_i,
   input  logic            done_i,
   input  logic [RA_W-1:0] rd_i,
   input  logic [BK_W-1:0] bank_i,
   input  logic            wen_i,
   output logic            busy_o,
   output logic [RA_W-1:0] wb_rd_o,
   output logic [BK_W-1:0] wb_bank_o,
   output logic            wb_wen_o,
   output logic            timeout_o
);

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(TIMEOUT - 2);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   unit_state_t      state_q, state_d;
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // A fire is only granted when the unit is idle or completing this cycle,
   // so it always lands in BUSY regardless of the current state.
   always_comb begin
      state_d = state_q;
      if (flush_i) begin
         state_d = ST_IDLE;
      end else if (fire_i) begin
         state_d = ST_BUSY;
      end else begin
         case (state_q)
            ST_BUSY: begin
               if (done_i)                 state_d = ST_IDLE;
               else if (cnt_q == CNT_PRE)  state_d = ST_TMO;
            end
            ST_TMO: begin
               if (done_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy_o = (state_q != ST_IDLE);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i || fire_i) begin
         cnt_q <= '0;
      end else if (state_q == ST_BUSY && !done_i && cnt_q != CNT_LAST) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) begin
         timeout_o <= 1'b0;
      end else if (state_q == ST_BUSY && state_d == ST_TMO) begin
         timeout_o <= 1'b1;
      end
   end

   // Held past completion so writeback can still sample them in the done cycle.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         wb_rd_o   <= '0;
         wb_bank_o <= '0;
         wb_wen_o  <= 1'b0;
      end else if (fire_i) begin
         wb_rd_o   <= rd_i;
         wb_bank_o <= bank_i;
         wb_wen_o  <= wen_i;
      end
   end

endmodule

// File: rtl/mc_hazard_scoreboard.sv
// ID-stage scoreboard for long-latency units: pending-register array, RAW/WAW/
// busy hazard detection with same-cycle completion bypass, spurious-done flag.
module mc_hazard_scoreboard
   import mc_hazard_scoreboard_pkg::*;
#(
   parameter int NREGS   = 32,
   parameter int NBANKS  = 2,
   parameter int NUNITS  = 2,
   parameter int TIMEOUT = 64,
   parameter int RA_W    = $clog2(NREGS),
   parameter int BK_W    = (NBANKS > 1) ? $clog2(NBANKS) : 1,
   parameter int U_W     = (NUNITS > 1) ? $clog2(NUNITS) : 1
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic                   issue_valid_i,
   input  logic [U_W-1:0]         issue_unit_i,
   input  logic [RA_W-1:0]        issue_rd_i,
   input  logic [BK_W-1:0]        issue_rd_bank_i,
   input  logic                   issue_wen_i,
   input  logic [3*RA_W-1:0]      rs_i,
   input  logic [3*BK_W-1:0]      rs_bank_i,
   input  logic [2:0]             rs_use_i,
   input  logic                   chk_valid_i,
   input  logic [RA_W-1:0]        chk_rd_i,
   input  logic [BK_W-1:0]        chk_rd_bank_i,
   input  logic                   chk_wen_i,
   input  logic [NUNITS-1:0]      done_i,
   input  logic                   flush_i,
   output logic                   stall_o,
   output logic                   issue_fire_o,
   output logic [NUNITS-1:0]      busy_o,
   output logic [NUNITS*RA_W-1:0] wb_rd_o,
   output logic [NUNITS*BK_W-1:0] wb_bank_o,
   output logic [NUNITS-1:0]      wb_wen_o,
   output logic [NUNITS-1:0]      timeout_o,
   output logic                   spurious_o
);

   logic [NBANKS-1:0][NREGS-1:0] pending_q, pending_d, clr, set_mask, pend_eff;
   logic [NUNITS-1:0]            busy, unit_fire, wb_wen, timeout;
   logic [NUNITS-1:0][RA_W-1:0]  wb_rd;
   logic [NUNITS-1:0][BK_W-1:0]  wb_bank;
   logic                         raw_hz, waw_hz, busy_hz, stall, fire;

   // Registers owned by units completing now are treated as already free.
   always_comb begin
      clr = '0;
      for (int u = 0; u < NUNITS; u++) begin
         if (done_i[u] && busy[u] && wb_wen[u]) clr[wb_bank[u]][wb_rd[u]] = 1'b1;
      end
      pend_eff = pending_q & ~clr;
   end

   always_comb begin
      raw_hz = 1'b0;
      for (int k = 0; k < 3; k++) begin
         if (rs_use_i[k] && pend_eff[rs_bank_i[k*BK_W +: BK_W]][rs_i[k*RA_W +: RA_W]])
            raw_hz = 1'b1;
      end
      waw_hz = (issue_valid_i && issue_wen_i && pend_eff[issue_rd_bank_i][issue_rd_i]) ||
               (chk_valid_i && chk_wen_i && pend_eff[chk_rd_bank_i][chk_rd_i]);
      busy_hz = issue_valid_i && busy[issue_unit_i] && !done_i[issue_unit_i];
      stall   = !reset_i && !flush_i &&
                (((issue_valid_i || chk_valid_i) && raw_hz) || waw_hz || busy_hz);
      fire    = !reset_i && !flush_i && issue_valid_i && !stall;
   end

   // x0 of the integer bank is hardwired, so it never becomes pending.
   always_comb begin
      set_mask = '0;
      if (fire && issue_wen_i &&
          !(issue_rd_bank_i == BK_W'(BANK_INT) && issue_rd_i == '0))
         set_mask[issue_rd_bank_i][issue_rd_i] = 1'b1;
      pending_d = pend_eff | set_mask;
      for (int u = 0; u < NUNITS; u++) begin
         unit_fire[u] = fire && (issue_unit_i == U_W'(u));
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i || flush_i) pending_q <= '0;
      else                    pending_q <= pending_d;
   end

   for (genvar g = 0; g < NUNITS; g++) begin : g_unit
      mc_unit_tracker #(
         .RA_W    (RA_W),
         .BK_W    (BK_W),
         .TIMEOUT (TIMEOUT)
      ) u_tracker (
         .clk_i     (clk_i),
         .reset_i   (reset_i),
         .flush_i   (flush_i),
         .fire_i    (unit_fire[g]),
         .done_i    (done_i[g]),
         .rd_i      (issue_rd_i),
         .bank_i    (issue_rd_bank_i),
         .wen_i     (issue_wen_i),
         .busy_o    (busy[g]),
         .wb_rd_o   (wb_rd[g]),
         .wb_bank_o (wb_bank[g]),
         .wb_wen_o  (wb_wen[g]),
         .timeout_o (timeout[g])
      );

      assign wb_rd_o[g*RA_W +: RA_W]   = wb_rd[g];
      assign wb_bank_o[g*BK_W +: BK_W] = wb_bank[g];
   end

   assign stall_o      = stall;
   assign issue_fire_o = fire;
   assign busy_o       = busy;
   assign wb_wen_o     = wb_wen;
   assign timeout_o    = timeout;
   assign spurious_o   = !reset_i && !flush_i && |(done_i & ~busy);

endmodule

// File: tb/tb_mc_hazard_scoreboard.sv
// Self-checking bench: directed scenarios then random traffic, all compared
// each cycle against a register/unit-level reference model.
module tb_mc_hazard_scoreboard;
   import mc_hazard_scoreboard_pkg::*;

   localparam int NREGS   = 32;
   localparam int NBANKS  = 2;
   localparam int NUNITS  = 2;
   localparam int TIMEOUT = 8;

   logic        clk_i = 1'b0;
   logic        reset_i;
   logic        issue_valid_i;
   logic [0:0]  issue_unit_i;
   logic [4:0]  issue_rd_i;
   logic [0:0]  issue_rd_bank_i;
   logic        issue_wen_i;
   logic [14:0] rs_i;
   logic [2:0]  rs_bank_i;
   logic [2:0]  rs_use_i;
   logic        chk_valid_i;
   logic [4:0]  chk_rd_i;
   logic [0:0]  chk_rd_bank_i;
   logic        chk_wen_i;
   logic [1:0]  done_i;
   logic        flush_i;
   logic        stall_o;
   logic        issue_fire_o;
   logic [1:0]  busy_o;
   logic [9:0]  wb_rd_o;
   logic [1:0]  wb_bank_o;
   logic [1:0]  wb_wen_o;
   logic [1:0]  timeout_o;
   logic        spurious_o;

   always #5 clk_i = ~clk_i;

   mc_hazard_scoreboard #(
      .NREGS   (NREGS),
      .NBANKS  (NBANKS),
      .NUNITS  (NUNITS),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk_i           (clk_i),
      .reset_i         (reset_i),
      .issue_valid_i   (issue_valid_i),
      .issue_unit_i    (issue_unit_i),
      .issue_rd_i      (issue_rd_i),
      .issue_rd_bank_i (issue_rd_bank_i),
      .issue_wen_i     (issue_wen_i),
      .rs_i            (rs_i),
      .rs_bank_i       (rs_bank_i),
      .rs_use_i        (rs_use_i),
      .chk_valid_i     (chk_valid_i),
      .chk_rd_i        (chk_rd_i),
      .chk_rd_bank_i   (chk_rd_bank_i),
      .chk_wen_i       (chk_wen_i),
      .done_i          (done_i),
      .flush_i         (flush_i),
      .stall_o         (stall_o),
      .issue_fire_o    (issue_fire_o),
      .busy_o          (busy_o),
      .wb_rd_o         (wb_rd_o),
      .wb_bank_o       (wb_bank_o),
      .wb_wen_o        (wb_wen_o),
      .timeout_o       (timeout_o),
      .spurious_o      (spurious_o)
   );

   // Reference model: which registers await a unit, and what each unit holds.
   bit       m_pend [NBANKS][NREGS];
   bit       m_busy [NUNITS];
   int       m_age  [NUNITS];
   bit       m_tmo  [NUNITS];
   bit [4:0] m_rd   [NUNITS];
   bit       m_bank [NUNITS];
   bit       m_wen  [NUNITS];
   bit       model_valid = 1'b0;

   bit e_clr [NBANKS][NREGS];
   bit e_stall, e_fire, e_spur;

   int num_vectors = 0;
   int num_miscompares = 0;

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      num_vectors++;
      if (observed !== expected) begin
         num_miscompares++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at t=%0t",
                  tag, observed, expected, $time);
      end
   endtask

   function automatic bit isPending(input bit b, input bit [4:0] r);
      return m_pend[b][r] && !e_clr[b][r];
   endfunction

   task automatic computeExpected();
      bit raw, waw, bhz;
      foreach (e_clr[b, r]) e_clr[b][r] = 1'b0;
      for (int u = 0; u < NUNITS; u++)
         if (m_busy[u] && done_i[u] && m_wen[u]) e_clr[m_bank[u]][m_rd[u]] = 1'b1;
      raw = 1'b0;
      for (int k = 0; k < 3; k++)
         if (rs_use_i[k] && isPending(rs_bank_i[k], rs_i[k*5 +: 5])) raw = 1'b1;
      waw = (issue_valid_i && issue_wen_i && isPending(issue_rd_bank_i, issue_rd_i)) ||
            (chk_valid_i && chk_wen_i && isPending(chk_rd_bank_i, chk_rd_i));
      bhz = issue_valid_i && m_busy[issue_unit_i] && !done_i[issue_unit_i];
      e_stall = !reset_i && !flush_i && (((issue_valid_i || chk_valid_i) && raw) || waw || bhz);
      e_fire  = !reset_i && !flush_i && issue_valid_i && !e_stall;
      e_spur  = 1'b0;
      for (int u = 0; u < NUNITS; u++)
         if (!reset_i && !flush_i && done_i[u] && !m_busy[u]) e_spur = 1'b1;
   endtask

   task automatic updateModel();
      if (reset_i) begin
         foreach (m_pend[b, r]) m_pend[b][r] = 1'b0;
         for (int u = 0; u < NUNITS; u++) begin
            m_busy[u] = 0; m_age[u] = 0; m_tmo[u] = 0;
            m_rd[u] = 0; m_bank[u] = 0; m_wen[u] = 0;
         end
         model_valid = 1'b1;
      end else if (flush_i) begin
         foreach (m_pend[b, r]) m_pend[b][r] = 1'b0;
         for (int u = 0; u < NUNITS; u++) begin
            m_busy[u] = 0; m_age[u] = 0; m_tmo[u] = 0;
         end
      end else begin
         foreach (m_pend[b, r]) if (e_clr[b][r]) m_pend[b][r] = 1'b0;
         for (int u = 0; u < NUNITS; u++) begin
            if (m_busy[u] && done_i[u]) begin
               m_busy[u] = 1'b0;
            end else if (m_busy[u] && !(e_fire && issue_unit_i == u)) begin
               m_age[u]++;
               if (m_age[u] >= TIMEOUT) m_tmo[u] = 1'b1;
            end
         end
         if (e_fire) begin
            m_busy[issue_unit_i] = 1'b1;
            m_age[issue_unit_i]  = 1;
            m_rd[issue_unit_i]   = issue_rd_i;
            m_bank[issue_unit_i] = issue_rd_bank_i;
            m_wen[issue_unit_i]  = issue_wen_i;
            if (issue_wen_i && !(issue_rd_bank_i == BANK_INT && issue_rd_i == 0))
               m_pend[issue_rd_bank_i][issue_rd_i] = 1'b1;
         end
      end
   endtask

   // One clock: compare at the falling edge, then advance the model on the rising edge.
   task automatic applyStimulus();
      logic [9:0] x_rd;
      logic [1:0] x_bank, x_wen, x_busy, x_tmo;
      @(negedge clk_i);
      computeExpected();
      if (model_valid) begin
         for (int u = 0; u < NUNITS; u++) begin
            x_rd[u*5 +: 5] = m_rd[u];
            x_bank[u] = m_bank[u];
            x_wen[u]  = m_wen[u];
            x_busy[u] = m_busy[u];
            x_tmo[u]  = m_tmo[u];
         end
         checkOutput("stall",    32'(stall_o),      32'(e_stall));
         checkOutput("fire",     32'(issue_fire_o), 32'(e_fire));
         checkOutput("spurious", 32'(spurious_o),   32'(e_spur));
         checkOutput("busy",     32'(busy_o),       32'(x_busy));
         checkOutput("timeout",  32'(timeout_o),    32'(x_tmo));
         checkOutput("wb_rd",    32'(wb_rd_o),      32'(x_rd));
         checkOutput("wb_bank",  32'(wb_bank_o),    32'(x_bank));
         checkOutput("wb_wen",   32'(wb_wen_o),     32'(x_wen));
      end
      @(posedge clk_i);
      updateModel();
      #1;
   endtask

   task automatic clearInputs();
      reset_i = 0; issue_valid_i = 0; issue_unit_i = 0; issue_rd_i = 0;
      issue_rd_bank_i = 0; issue_wen_i = 0; rs_i = 0; rs_bank_i = 0; rs_use_i = 0;
      chk_valid_i = 0; chk_rd_i = 0; chk_rd_bank_i = 0; chk_wen_i = 0;
      done_i = 0; flush_i = 0;
   endtask

   task automatic setIssue(input int u, input int rd, input int bank, input bit wen);
      issue_valid_i = 1; issue_unit_i = 1'(u); issue_rd_i = 5'(rd);
      issue_rd_bank_i = 1'(bank); issue_wen_i = wen;
   endtask

   task automatic setRs1(input int rd, input int bank);
      rs_i = 15'(rd); rs_bank_i = 3'(bank); rs_use_i = 3'b001;
   endtask

   task automatic setChkRd(input int rd, input int bank);
      chk_valid_i = 1; chk_rd_i = 5'(rd); chk_rd_bank_i = 1'(bank); chk_wen_i = 1;
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation exceeded its time limit");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      clearInputs();
      reset_i = 1;
      applyStimulus();
      applyStimulus();
      clearInputs();
      applyStimulus();

      // RAW on a MULDIV result, resolved by the completion bypass.
      setIssue(UNIT_MULDIV, 5, BANK_INT, 1); applyStimulus(); clearInputs();
      chk_valid_i = 1; setRs1(5, BANK_INT); applyStimulus(); applyStimulus();
      done_i = 2'b01; applyStimulus(); clearInputs();

      // WAW on an FP destination; integer bank with same index is independent.
      setIssue(UNIT_FPU, 3, BANK_FP, 1); applyStimulus(); clearInputs();
      setChkRd(3, BANK_FP); applyStimulus();
      setChkRd(3, BANK_INT); applyStimulus(); clearInputs();
      done_i = 2'b10; applyStimulus(); clearInputs();
      setIssue(UNIT_MULDIV, 0, BANK_INT, 1); applyStimulus(); clearInputs();
      chk_valid_i = 1; setRs1(0, BANK_INT); applyStimulus();
      done_i = 2'b01; applyStimulus(); clearInputs();

      // Back-to-back issue on completion, then a busy stall.
      setIssue(UNIT_MULDIV, 9, BANK_INT, 1); applyStimulus();
      setIssue(UNIT_MULDIV, 10, BANK_INT, 1); done_i = 2'b01; applyStimulus();
      done_i = 2'b00; setIssue(UNIT_MULDIV, 11, BANK_INT, 1); applyStimulus(); clearInputs();
      done_i = 2'b01; applyStimulus(); clearInputs();

      // Timeout, late completion, then flush clears the sticky flag.
      setIssue(UNIT_FPU, 12, BANK_FP, 1); applyStimulus(); clearInputs();
      for (int i = 0; i < TIMEOUT + 2; i++) applyStimulus();
      done_i = 2'b10; applyStimulus(); clearInputs();
      applyStimulus();
      flush_i = 1; applyStimulus(); clearInputs();
      applyStimulus();

      // Spurious completion, with and without a concurrent flush.
      done_i = 2'b01; applyStimulus(); clearInputs(); applyStimulus();
      done_i = 2'b01; flush_i = 1; applyStimulus(); clearInputs();

      // Simultaneous completion of both units, then reset while busy.
      setIssue(UNIT_MULDIV, 7, BANK_INT, 1); applyStimulus();
      setIssue(UNIT_FPU, 7, BANK_FP, 1); applyStimulus(); clearInputs();
      done_i = 2'b11; chk_valid_i = 1;
      rs_i = {5'd0, 5'd7, 5'd7}; rs_bank_i = 3'b010; rs_use_i = 3'b011;
      applyStimulus(); clearInputs();
      setIssue(UNIT_FPU, 8, BANK_FP, 1); applyStimulus(); clearInputs();
      reset_i = 1; flush_i = 1; applyStimulus(); clearInputs();
      applyStimulus();

      for (int i = 0; i < 3000; i++) begin
         reset_i         = ($urandom_range(0, 199) == 0);
         flush_i         = ($urandom_range(0, 49) == 0);
         issue_valid_i   = ($urandom_range(0, 1) == 1);
         issue_unit_i    = 1'($urandom_range(0, 1));
         issue_rd_i      = 5'($urandom_range(0, 7));
         issue_rd_bank_i = 1'($urandom_range(0, 1));
         issue_wen_i     = ($urandom_range(0, 4) != 0);
         rs_i            = 15'($urandom_range(0, 32767)) & 15'b00111_00111_00111;
         rs_bank_i       = 3'($urandom_range(0, 7));
         rs_use_i        = 3'($urandom_range(0, 7));
         chk_valid_i     = ($urandom_range(0, 1) == 1);
         chk_rd_i        = 5'($urandom_range(0, 7));
         chk_rd_bank_i   = 1'($urandom_range(0, 1));
         chk_wen_i       = ($urandom_range(0, 1) == 1);
         done_i[0]       = ($urandom_range(0, 5) == 0);
         done_i[1]       = ($urandom_range(0, 9) == 0);
         applyStimulus();
      end

      clearInputs();
      applyStimulus();
      $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
      $finish;
   end

endmodule
